// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and constants, including the padder state set and the
// helper that truncates a final message word and appends the padding marker.
package sha256_pkg;

    localparam int SRC_IF_DATA_W      = 64;
    localparam int SHA_IF_DATA_W      = 4 * SRC_IF_DATA_W;
    localparam int MSG_LEN_W          = 64;
    localparam int SHA256_BLOCK_WORDS = 8;

    localparam logic [7:0] SHA256_PAD_MARKER = 8'h80;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        PAD    = 2'd1,
        FLUSH  = 2'd2
    } padder_state_e;

    // Keep bytes 0..n-1, put the marker at byte n, zero everything below it.
    // With n = 8 the word passes through unchanged.
    function automatic logic [SRC_IF_DATA_W-1:0] sha256_pad_last_word(
        input logic [SRC_IF_DATA_W-1:0] data,
        input logic [3:0]               nbytes
    );
        logic [SRC_IF_DATA_W-1:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) begin
                w[63-8*i -: 8] = data[63-8*i -: 8];
            end else if (4'(i) == nbytes) begin
                w[63-8*i -: 8] = SHA256_PAD_MARKER;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 64-bit message words into 256-bit half-blocks,
// then appends the marker, zero fill and the 64-bit bit length.
module sha256_padder
    import sha256_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     src_padder_data_val,
    input  logic [SRC_IF_DATA_W-1:0] src_padder_data,
    input  logic                     src_padder_data_last,
    input  logic [3:0]               src_padder_data_bytes,
    output logic                     padder_src_rdy,
    output logic                     padder_manager_data_val,
    output logic [SHA_IF_DATA_W-1:0] padder_manager_data,
    output logic                     padder_manager_data_last,
    input  logic                     manager_padder_rdy
);

    padder_state_e            state;
    logic [2:0]               slot;
    logic [60:0]              byte_cnt;
    logic                     marker_done;
    logic [SRC_IF_DATA_W-1:0] half_buf [4];
    logic                     buf_full;
    logic                     out_last;
    logic                     run;

    logic                     accept;
    logic                     handshake;
    logic                     wr_en;
    logic                     wr_is_len;
    logic [SRC_IF_DATA_W-1:0] wr_data;

    // run holds ready low while reset is asserted and rises on the first clock after release
    assign padder_src_rdy = run && (state == ACCEPT) && !buf_full;
    assign accept         = src_padder_data_val && padder_src_rdy;
    assign handshake      = buf_full && manager_padder_rdy;

    assign padder_manager_data_val  = buf_full;
    assign padder_manager_data_last = out_last;
    assign padder_manager_data      = {half_buf[0], half_buf[1], half_buf[2], half_buf[3]};

    always_comb begin
        wr_en     = 1'b0;
        wr_is_len = 1'b0;
        wr_data   = '0;
        if (state == ACCEPT) begin
            if (accept) begin
                wr_en   = 1'b1;
                wr_data = src_padder_data_last
                        ? sha256_pad_last_word(src_padder_data, src_padder_data_bytes)
                        : src_padder_data;
            end
        end else if (state == PAD && !buf_full) begin
            wr_en = 1'b1;
            if (!marker_done) begin
                wr_data = {SHA256_PAD_MARKER, 56'h0};
            end else if (slot == 3'(SHA256_BLOCK_WORDS - 1)) begin
                wr_data   = {byte_cnt, 3'b000};
                wr_is_len = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ACCEPT;
            slot        <= 3'd0;
            byte_cnt    <= '0;
            marker_done <= 1'b0;
            buf_full    <= 1'b0;
            out_last    <= 1'b0;
            run         <= 1'b0;
            for (int i = 0; i < 4; i++) half_buf[i] <= '0;
        end else begin
            run <= 1'b1;

            // Writes require an empty buffer, so a drain never collides with a write.
            if (handshake) begin
                buf_full <= 1'b0;
                out_last <= 1'b0;
                for (int i = 0; i < 4; i++) half_buf[i] <= '0;
            end

            if (wr_en) begin
                half_buf[slot[1:0]] <= wr_data;
                slot                <= slot + 3'd1;
                if (slot[1:0] == 2'd3) buf_full <= 1'b1;
                if (wr_is_len)         out_last <= 1'b1;
            end

            case (state)
                ACCEPT: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 61'(src_padder_data_bytes);
                        if (src_padder_data_last) begin
                            marker_done <= (src_padder_data_bytes != 4'd8);
                            state       <= PAD;
                        end
                    end
                end
                PAD: begin
                    if (wr_en) begin
                        if (!marker_done) begin
                            marker_done <= 1'b1;
                        end else if (wr_is_len) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (handshake) begin
                        byte_cnt    <= '0;
                        slot        <= 3'd0;
                        marker_done <= 1'b0;
                        state       <= ACCEPT;
                    end
                end
                default: state <= ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: directed messages plus random ones,
// compared against a byte-level padding model.
module tb_sha256_padder;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         src_padder_data_val = 1'b0;
    logic [63:0]  src_padder_data = '0;
    logic         src_padder_data_last = 1'b0;
    logic [3:0]   src_padder_data_bytes = '0;
    logic         padder_src_rdy;
    logic         padder_manager_data_val;
    logic [255:0] padder_manager_data;
    logic         padder_manager_data_last;
    logic         manager_padder_rdy = 1'b0;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

    byte unsigned msg [256];
    logic [255:0] exp_d [$];
    logic         exp_l [$];

    sha256_padder dut (
        .clk                      (clk),
        .rst                      (rst),
        .src_padder_data_val      (src_padder_data_val),
        .src_padder_data          (src_padder_data),
        .src_padder_data_last     (src_padder_data_last),
        .src_padder_data_bytes    (src_padder_data_bytes),
        .padder_src_rdy           (padder_src_rdy),
        .padder_manager_data_val  (padder_manager_data_val),
        .padder_manager_data      (padder_manager_data),
        .padder_manager_data_last (padder_manager_data_last),
        .manager_padder_rdy       (manager_padder_rdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       manager_padder_rdy = 1'b1;
            1:       manager_padder_rdy = 1'($urandom_range(0, 1));
            default: manager_padder_rdy = 1'b0;
        endcase
    end

    // Output scoreboard: every accepted half-block is popped and compared in order.
    always @(negedge clk) begin
        logic [255:0] d;
        logic         l;
        if (rst && padder_manager_data_val && manager_padder_rdy) begin
            checks++;
            assert (exp_d.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_half got %h expected none", padder_manager_data);
            end
            if (exp_d.size() > 0) begin
                d = exp_d.pop_front();
                l = exp_l.pop_front();
                checks++;
                assert (padder_manager_data === d) else begin
                    errors++;
                    $error("FAIL half_data got %h expected %h", padder_manager_data, d);
                end
                checks++;
                assert (padder_manager_data_last === l) else begin
                    errors++;
                    $error("FAIL half_last got %b expected %b", padder_manager_data_last, l);
                end
            end
        end
    end

    // Reference: build the padded byte string, then cut it into 32-byte halves.
    task automatic model_msg(input int len);
        byte unsigned p [$];
        logic [63:0]  bits;
        logic [255:0] d;
        int           nh;
        for (int i = 0; i < len; i++) p.push_back(msg[i]);
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bits = 64'(len) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(bits[8*k+7 -: 8]);
        nh = p.size() / 32;
        for (int h = 0; h < nh; h++) begin
            d = '0;
            for (int b = 0; b < 32; b++) d[255-8*b -: 8] = p[32*h+b];
            exp_d.push_back(d);
            exp_l.push_back(h == nh - 1);
        end
    endtask

    task automatic send_word(input logic [63:0] data, input logic last, input logic [3:0] nb);
        bit ok;
        int waited;
        ok = 1'b0;
        waited = 0;
        src_padder_data_val   = 1'b1;
        src_padder_data       = data;
        src_padder_data_last  = last;
        src_padder_data_bytes = nb;
        while (!ok && waited < 2000) begin
            @(negedge clk);
            ok = padder_src_rdy;
            @(posedge clk);
            #1;
            waited++;
        end
        src_padder_data_val = 1'b0;
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL send_timeout got rdy=%b expected 1", ok);
        end
    endtask

    // Unused bytes of the last word carry random junk to prove they get masked.
    task automatic send_msg(input int len);
        int          nw;
        int          idx;
        logic [63:0] w;
        nw = (len == 0) ? 1 : (len + 7) / 8;
        for (int k = 0; k < nw; k++) begin
            for (int b = 0; b < 8; b++) begin
                idx = 8 * k + b;
                w[63-8*b -: 8] = (idx < len) ? msg[idx] : 8'($urandom);
            end
            if (k == nw - 1) send_word(w, 1'b1, 4'(len - 8 * k));
            else             send_word(w, 1'b0, 4'd8);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_d.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        assert (exp_d.size() == 0) else begin
            errors++;
            $error("FAIL %s_drain got %0d halves pending expected 0", tag, exp_d.size());
        end
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
    endtask

    task automatic load_abc();
        msg[0] = 8'h61;
        msg[1] = 8'h62;
        msg[2] = 8'h63;
    endtask

    initial begin
        logic [255:0] cap;
        logic [63:0]  w;
        int           n;

        // Reset state
        #12;
        checks++; assert (padder_manager_data_val === 1'b0) else begin errors++; $error("FAIL rst_val got %b expected 0", padder_manager_data_val); end
        checks++; assert (padder_manager_data === 256'h0) else begin errors++; $error("FAIL rst_data got %h expected 0", padder_manager_data); end
        checks++; assert (padder_manager_data_last === 1'b0) else begin errors++; $error("FAIL rst_last got %b expected 0", padder_manager_data_last); end
        checks++; assert (padder_src_rdy === 1'b0) else begin errors++; $error("FAIL rst_rdy got %b expected 0", padder_src_rdy); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; assert (padder_src_rdy === 1'b1) else begin errors++; $error("FAIL rdy_after_rst got %b expected 1", padder_src_rdy); end

        // "abc" with literal expected halves
        load_abc();
        exp_d.push_back({32'h61626380, 224'h0}); exp_l.push_back(1'b0);
        exp_d.push_back({192'h0, 64'h18});       exp_l.push_back(1'b1);
        send_msg(3);
        drain("abc");

        // Empty message
        exp_d.push_back({8'h80, 248'h0}); exp_l.push_back(1'b0);
        exp_d.push_back(256'h0);          exp_l.push_back(1'b1);
        send_msg(0);
        drain("empty");

        // 55 and 56 bytes: one versus two final blocks
        fill_random(55);
        model_msg(55);
        send_msg(55);
        drain("len55");
        fill_random(56);
        model_msg(56);
        checks++; assert (exp_d.size() == 4) else begin errors++; $error("FAIL len56_halves got %0d expected 4", exp_d.size()); end
        send_msg(56);
        drain("len56");

        // Backpressure on half 0
        fill_random(40);
        model_msg(40);
        rdy_mode = 2;
        fork
            send_msg(40);
            begin
                n = 0;
                while (!padder_manager_data_val && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                checks++; assert (padder_manager_data_val === 1'b1) else begin errors++; $error("FAIL bp_val got %b expected 1", padder_manager_data_val); end
                cap = padder_manager_data;
                repeat (10) begin
                    @(negedge clk);
                    checks++; assert (padder_manager_data === cap) else begin errors++; $error("FAIL bp_hold got %h expected %h", padder_manager_data, cap); end
                    checks++; assert (padder_src_rdy === 1'b0) else begin errors++; $error("FAIL bp_rdy got %b expected 0", padder_src_rdy); end
                end
                rdy_mode = 0;
            end
        join
        drain("bp");

        // Random messages under random downstream readiness
        rdy_mode = 1;
        for (int m = 0; m < 8; m++) begin
            n = int'($urandom_range(0, 150));
            fill_random(n);
            model_msg(n);
            send_msg(n);
        end
        drain("random");
        rdy_mode = 0;

        // Reset after 5 words: half 0 of raw data drains, then everything is discarded
        fill_random(40);
        cap = '0;
        for (int b = 0; b < 32; b++) cap[255-8*b -: 8] = msg[b];
        exp_d.push_back(cap); exp_l.push_back(1'b0);
        for (int k = 0; k < 5; k++) begin
            for (int b = 0; b < 8; b++) w[63-8*b -: 8] = msg[8*k+b];
            send_word(w, 1'b0, 4'd8);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; assert (padder_manager_data_val === 1'b0) else begin errors++; $error("FAIL mid_rst_val got %b expected 0", padder_manager_data_val); end
        checks++; assert (padder_manager_data === 256'h0) else begin errors++; $error("FAIL mid_rst_data got %h expected 0", padder_manager_data); end
        checks++; assert (padder_src_rdy === 1'b0) else begin errors++; $error("FAIL mid_rst_rdy got %b expected 0", padder_src_rdy); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; assert (exp_d.size() == 0) else begin errors++; $error("FAIL mid_rst_pending got %0d expected 0", exp_d.size()); end
        load_abc();
        exp_d.push_back({32'h61626380, 224'h0}); exp_l.push_back(1'b0);
        exp_d.push_back({192'h0, 64'h18});       exp_l.push_back(1'b1);
        send_msg(3);
        drain("abc_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
